// File: rtl/multi_channel_pulsifier.sv
// multi_channel_pulsifier
//
// Turns level changes on channel_count independent, already-synchronous inputs
// into registered pulses lasting pulse_duration clock cycles.
//
// Parameters:
//   channel_count  - number of independent channels (>= 1)
//   pulse_duration - pulse length in clock cycles (>= 1)
//   edge_mode      - 0 = rising, 1 = falling, 2 = both edges trigger
//   retrigger      - 0 = edges during a pulse are dropped (flagged on overrun),
//                    1 = an edge reloads the pulse to its full length
//
// Ports:
//   clock            - system clock, rising edge
//   reset            - synchronous, active-high reset
//   enable           - per-channel enable; low suppresses new triggers
//   original_signal  - level inputs
//   pulsified_signal - registered pulse outputs
//   busy             - channel counter non-zero (same as pulsified_signal)
//   overrun          - one-cycle strobe: a trigger edge was dropped
module multi_channel_pulsifier #(
    parameter int unsigned channel_count  = 4,
    parameter int unsigned pulse_duration = 1,
    parameter int unsigned edge_mode      = 0,
    parameter int unsigned retrigger      = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [channel_count-1:0] enable,
    input  logic [channel_count-1:0] original_signal,
    output logic [channel_count-1:0] pulsified_signal,
    output logic [channel_count-1:0] busy,
    output logic [channel_count-1:0] overrun
);

    // Kept at least one bit wide so an illegal pulse_duration reaches the
    // parameter check below instead of failing on a zero-width vector.
    localparam int unsigned CountWidth =
        (pulse_duration < 2) ? 1 : $clog2(pulse_duration + 1);
    localparam logic [CountWidth-1:0] Reload = CountWidth'(pulse_duration);
    localparam logic [CountWidth-1:0] One    = CountWidth'(1);

    if (channel_count < 1 || pulse_duration < 1 || edge_mode > 2) begin : g_bad_params
        $error("multi_channel_pulsifier: illegal parameter combination");
    end

    logic [channel_count-1:0] prev_q;
    logic [channel_count-1:0] rise;
    logic [channel_count-1:0] fall;
    logic [channel_count-1:0] trig;

    always_comb begin
        rise = original_signal & ~prev_q;
        fall = ~original_signal & prev_q;
        case (edge_mode)
            0:       trig = rise & enable;
            1:       trig = fall & enable;
            default: trig = (rise | fall) & enable;
        endcase
    end

    // prev tracks the input regardless of enable so re-enabling a channel
    // whose input is already high cannot look like an edge. Loading it during
    // reset suppresses a pulse for inputs that are high at reset release.
    always_ff @(posedge clock) begin
        prev_q <= original_signal;
    end

    for (genvar i = 0; i < int'(channel_count); i++) begin : g_chan
        logic [CountWidth-1:0] count_q;
        logic                  overrun_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                count_q   <= '0;
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= 1'b0;
                if (trig[i]) begin
                    // A trigger in the final pulse cycle is accepted even
                    // without retrigger so back-to-back pulses have no gap.
                    if (count_q == '0 || retrigger != 0 || count_q == One) begin
                        count_q <= Reload;
                    end else begin
                        count_q   <= count_q - One;
                        overrun_q <= 1'b1;
                    end
                end else if (count_q != '0) begin
                    count_q <= count_q - One;
                end
            end
        end

        assign pulsified_signal[i] = (count_q != '0);
        assign overrun[i]          = overrun_q;
    end

    assign busy = pulsified_signal;

endmodule

// File: tb/tb_multi_channel_pulsifier.sv
module tb_multi_channel_pulsifier;

    localparam int ND = 6;

    // Configurations under test: {pulse_duration, edge_mode, retrigger}
    function automatic int pd_of(input int g);
        case (g)
            0: return 3;
            1: return 2;
            2: return 4;
            3: return 5;
            4: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int em_of(input int g);
        case (g)
            1: return 2;
            4: return 2;
            5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int rt_of(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] enable;
    logic [3:0] orig;
    logic [3:0] pul [ND];
    logic [3:0] bsy [ND];
    logic [3:0] ovr [ND];

    always #5 clock = ~clock;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        multi_channel_pulsifier #(
            .channel_count  (4),
            .pulse_duration (pd_of(g)),
            .edge_mode      (em_of(g)),
            .retrigger      (rt_of(g))
        ) dut (
            .clock            (clock),
            .reset            (reset),
            .enable           (enable),
            .original_signal  (orig),
            .pulsified_signal (pul[g]),
            .busy             (bsy[g]),
            .overrun          (ovr[g])
        );
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a pulse is high after edge k iff the most recent
    // accepted trigger happened fewer than pulse_duration edges ago.
    int         cyc = 0;
    logic       prev_m   [ND][4];
    int         last_acc [ND][4];
    logic [3:0] exp_p    [ND];
    logic [3:0] exp_o    [ND];

    task automatic check(input string name, input int d, input logic [3:0] got,
                         input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %b, expected %b", name, d, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        logic rise, fall, tr, ov;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (reset) begin
                    prev_m[d][c]   = orig[c];
                    last_acc[d][c] = -1000;
                    exp_p[d][c]    = 1'b0;
                    exp_o[d][c]    = 1'b0;
                end else begin
                    rise = orig[c] & ~prev_m[d][c];
                    fall = ~orig[c] & prev_m[d][c];
                    tr   = (em_of(d) == 0) ? rise : (em_of(d) == 1) ? fall : (rise | fall);
                    tr   = tr & enable[c];
                    ov   = 1'b0;
                    if (tr) begin
                        if (rt_of(d) != 0 || cyc - last_acc[d][c] >= pd_of(d))
                            last_acc[d][c] = cyc;
                        else
                            ov = 1'b1;
                    end
                    prev_m[d][c] = orig[c];
                    exp_p[d][c]  = (cyc - last_acc[d][c] < pd_of(d));
                    exp_o[d][c]  = ov;
                end
            end
        end
        cyc++;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        for (int d = 0; d < ND; d++) begin
            check("model_pulse", d, pul[d], exp_p[d]);
            check("model_busy", d, bsy[d], exp_p[d]);
            check("model_overrun", d, ovr[d], exp_o[d]);
        end
    endtask

    task automatic quiet();
        orig   = 4'b0000;
        enable = 4'b1111;
        repeat (6) tick();
    endtask

    typedef struct {
        logic [3:0] orig;
        logic [3:0] en;
        logic [3:0] exp_p;
        logic [3:0] exp_o;
    } vec_t;

    vec_t tbl [20];

    initial begin
        // Directed vectors for dut0 (pulse_duration=3, rising, no retrigger).
        tbl[0]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0000};
        tbl[6]  = '{4'b0000, 4'b1111, 4'b0001, 4'b0000};
        tbl[7]  = '{4'b0001, 4'b1111, 4'b0001, 4'b0001};
        tbl[8]  = '{4'b0001, 4'b1111, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0011, 4'b1111, 4'b0011, 4'b0000};
        tbl[11] = '{4'b0011, 4'b1111, 4'b0011, 4'b0000};
        tbl[12] = '{4'b0010, 4'b1111, 4'b0011, 4'b0000};
        tbl[13] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000};
        tbl[14] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000};
        tbl[15] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
        tbl[16] = '{4'b1111, 4'b1111, 4'b1110, 4'b0000};
        tbl[17] = '{4'b0111, 4'b0111, 4'b1110, 4'b0000};
        tbl[18] = '{4'b1111, 4'b0111, 4'b0000, 4'b0000};
        tbl[19] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};

        // Reset with all inputs high, then release: nothing may pulse.
        reset  = 1'b1;
        orig   = 4'b1111;
        enable = 4'b1111;
        repeat (2) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                check("reset_pulse", d, pul[d], 4'b0000);
                check("reset_overrun", d, ovr[d], 4'b0000);
            end
        end
        reset = 1'b0;
        repeat (3) begin
            tick();
            for (int d = 0; d < ND; d++) check("release_high_no_pulse", d, pul[d], 4'b0000);
        end
        quiet();

        for (int i = 0; i < 20; i++) begin
            orig   = tbl[i].orig;
            enable = tbl[i].en;
            tick();
            check("table_pulse", 0, pul[0], tbl[i].exp_p);
            check("table_overrun", 0, ovr[0], tbl[i].exp_o);
        end
        quiet();

        // dut1 (both edges, duration 2): drop then final-cycle acceptance.
        orig = 4'b0010; tick();
        check("both_first", 1, pul[1], 4'b0010);
        check("both_first_ovr", 1, ovr[1], 4'b0000);
        orig = 4'b0000; tick();
        check("both_drop", 1, pul[1], 4'b0010);
        check("both_drop_ovr", 1, ovr[1], 4'b0010);
        orig = 4'b0010; tick();
        check("both_last_accept", 1, pul[1], 4'b0010);
        check("both_last_accept_ovr", 1, ovr[1], 4'b0000);
        tick();
        check("both_tail", 1, pul[1], 4'b0010);
        tick();
        check("both_end", 1, pul[1], 4'b0000);
        quiet();

        // dut2 (retrigger, duration 4): pulse extends from the last trigger.
        orig = 4'b0100; tick();
        check("retrig_start", 2, pul[2], 4'b0100);
        orig = 4'b0000; tick();
        check("retrig_mid", 2, pul[2], 4'b0100);
        orig = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("retrig_hold", 2, pul[2], 4'b0100);
            check("retrig_no_ovr", 2, ovr[2], 4'b0000);
        end
        tick();
        check("retrig_end", 2, pul[2], 4'b0000);
        quiet();

        // dut3 (duration 5): reset truncates a pulse in progress.
        orig = 4'b0001;
        repeat (3) begin
            tick();
            check("trunc_before", 3, pul[3], 4'b0001);
        end
        reset = 1'b1; tick();
        check("trunc_reset", 3, pul[3], 4'b0000);
        check("trunc_reset_busy", 3, bsy[3], 4'b0000);
        reset = 1'b0;
        repeat (5) begin
            tick();
            check("trunc_after", 3, pul[3], 4'b0000);
        end
        quiet();

        // dut4 (both edges, duration 1): toggling every cycle holds output high.
        for (int k = 0; k < 5; k++) begin
            orig[3] = ~orig[3];
            tick();
            check("toggle_hold", 4, pul[4], 4'b1000);
            check("toggle_no_ovr", 4, ovr[4], 4'b0000);
        end
        tick();
        check("toggle_end", 4, pul[4], 4'b0000);

        // Random traffic against the model.
        repeat (600) begin
            orig = 4'($urandom);
            for (int c = 0; c < 4; c++) enable[c] = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
